// File: rtl/div_seq_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, default width
// and the EX-stage ALU control codes that select DIV/DIVU.
package div_seq_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } divState_t;

    localparam logic [4:0] ALU_DIV  = 5'b01010;
    localparam logic [4:0] ALU_DIVU = 5'b01011;

    // Decode helpers for the EX stage: start and signed_div come from alucontrolE.
    function automatic logic isDivOp(input logic [4:0] aluControl);
        return (aluControl == ALU_DIV) || (aluControl == ALU_DIVU);
    endfunction

    function automatic logic isSignedDiv(input logic [4:0] aluControl);
        return aluControl == ALU_DIV;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, restore on borrow.
module div_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {remIn, quoIn[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        // A set MSB on the widened difference means the trial subtraction borrowed.
        if (diff[WIDTH]) begin
            remOut = shifted[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b0};
        end else begin
            remOut = diff[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequencer for the 32-cycle DIV/DIVU unit in EX: latches magnitudes, runs one
// restoring step per cycle under stall_div, then applies sign fixup into hilo_out.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic               cancel,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               stall_div,
    output logic               result_valid,
    output logic [2*WIDTH-1:0] hilo_out,
    output logic               div_by_zero
);

    localparam int COUNT_W = $clog2(WIDTH);

    divState_t          state;
    divState_t          stateNext;
    logic [COUNT_W-1:0] count;
    logic [WIDTH-1:0]   remReg;
    logic [WIDTH-1:0]   quoReg;
    logic [WIDTH-1:0]   divisorReg;
    logic [WIDTH-1:0]   rawDividend;
    logic               negQuo;
    logic               negRem;
    logic               divZero;
    logic [WIDTH-1:0]   stepRem;
    logic [WIDTH-1:0]   stepQuo;
    logic               accept;
    logic               lastStep;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic isSigned);
        return (isSigned && value[WIDTH-1]) ? -value : value;
    endfunction

    function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] value,
                                                   input logic neg);
        return neg ? -value : value;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .remIn  (remReg),
        .quoIn  (quoReg),
        .divisor(divisorReg),
        .remOut (stepRem),
        .quoOut (stepQuo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                count <= '0;
            end else if (state == DIV_RUN && !lastStep) begin
                count <= count + 1'b1;
            end
        end
    end

    always_comb begin
        stateNext    = state;
        stall_div    = 1'b0;
        result_valid = 1'b0;
        div_by_zero  = 1'b0;
        accept       = 1'b0;
        lastStep     = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (start && !cancel) begin
                    accept    = 1'b1;
                    stall_div = 1'b1;
                    stateNext = DIV_RUN;
                end
            end
            DIV_RUN: begin
                stall_div = 1'b1;
                lastStep  = (count == COUNT_W'(WIDTH - 1));
                if (cancel) begin
                    stateNext = DIV_IDLE;
                end else if (lastStep) begin
                    stateNext = DIV_DONE;
                end
            end
            DIV_DONE: begin
                result_valid = !cancel;
                div_by_zero  = !cancel && divZero;
                stateNext    = DIV_IDLE;
            end
            default: stateNext = DIV_IDLE;
        endcase
    end

    // Latch stage: quoReg starts as the dividend magnitude and is shifted out MSB-first.
    always_ff @(posedge clk) begin
        if (accept) begin
            remReg      <= '0;
            quoReg      <= magnitude(dividend, signed_div);
            divisorReg  <= magnitude(divisor, signed_div);
            rawDividend <= dividend;
            negQuo      <= signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            negRem      <= signed_div && dividend[WIDTH-1];
            divZero     <= (divisor == '0);
        end else if (state == DIV_RUN) begin
            remReg <= stepRem;
            quoReg <= stepQuo;
        end
    end

    // Result stage: final step plus sign fixup lands in hilo_out as DONE begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            hilo_out <= '0;
        end else if (state == DIV_RUN && lastStep && !cancel) begin
            if (divZero) begin
                hilo_out <= {rawDividend, {WIDTH{1'b1}}};
            end else begin
                hilo_out <= {applySign(stepRem, negRem), applySign(stepQuo, negQuo)};
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq against a plain-arithmetic
// DIV/DIVU reference, plus directed latency, cancel and reset scenarios.
module tb_div_seq;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic           cancel;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           stall_div;
    logic           result_valid;
    logic [2*W-1:0] hilo_out;
    logic           div_by_zero;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int lastValidCycle = 0;

    div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_div  (signed_div),
        .cancel      (cancel),
        .dividend    (dividend),
        .divisor     (divisor),
        .stall_div   (stall_div),
        .result_valid(result_valid),
        .hilo_out    (hilo_out),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkVal(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input string tag);
        int stallCnt = 0;
        int validAt  = -1;
        logic [63:0] expVal;
        expVal = refDiv(a, b, sgn);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start      = 1'b1;
                signed_div = sgn;
                dividend   = a;
                divisor    = b;
            end else begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            #1;
            if (stall_div) stallCnt++;
            if (result_valid) begin
                validAt = c;
                break;
            end
        end
        lastValidCycle = cycle;
        checkVal({tag, "_lat"},   64'(validAt), 64'd33);
        checkVal({tag, "_stall"}, 64'(stallCnt), 64'd33);
        checkVal({tag, "_hilo"},  hilo_out, expVal);
        checkVal({tag, "_dbz"},   64'(div_by_zero), 64'(b == 32'h0));
    endtask

    task automatic idleCycle(input string tag);
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        #1;
        checkVal({tag, "_idle_valid"}, 64'(result_valid), 64'd0);
        checkVal({tag, "_idle_stall"}, 64'(stall_div), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] prev;
        int          t1;
        bit          sawValid;

        rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_div = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        #1;
        checkVal("rst_hilo",  hilo_out, 64'd0);
        checkVal("rst_stall", 64'(stall_div), 64'd0);
        checkVal("rst_valid", 64'(result_valid), 64'd0);
        checkVal("rst_dbz",   64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        runDiv(32'd100, 32'd7, 1'b0, "divu_100_7");           idleCycle("t1");
        checkVal("divu_100_7_val", hilo_out, {32'd2, 32'd14});
        runDiv(-32'sd7, 32'd2, 1'b1, "div_m7_2");             idleCycle("t2a");
        checkVal("div_m7_2_val", hilo_out, {32'hFFFFFFFF, 32'hFFFFFFFD});
        runDiv(32'd7, -32'sd2, 1'b1, "div_7_m2");             idleCycle("t2b");
        checkVal("div_7_m2_val", hilo_out, {32'h00000001, 32'hFFFFFFFD});
        runDiv(32'hFFFFFFF9, 32'd2, 1'b0, "divu_big_2");      idleCycle("t2c");
        checkVal("divu_big_2_val", hilo_out, {32'd1, 32'h7FFFFFFC});
        runDiv(32'd5, 32'd0, 1'b0, "divu_5_0");               idleCycle("t3a");
        checkVal("divu_5_0_val", hilo_out, {32'd5, 32'hFFFFFFFF});
        runDiv(32'd6, 32'd3, 1'b0, "divu_6_3");               idleCycle("t3b");
        runDiv(32'h80000000, 32'hFFFFFFFF, 1'b1, "div_ovf");  idleCycle("t4a");
        checkVal("div_ovf_val", hilo_out, {32'd0, 32'h80000000});
        runDiv(32'h80000000, 32'd2, 1'b1, "div_min_2");       idleCycle("t4b");
        checkVal("div_min_2_val", hilo_out, {32'd0, 32'hC0000000});
        runDiv(32'hFFFFFFF9, 32'd0, 1'b1, "div_neg_0");       idleCycle("t4c");

        for (int i = 0; i < 20; i++) begin
            a   = $urandom;
            b   = $urandom;
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 16));
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            runDiv(a, b, sgn, $sformatf("rnd%0d", i));
            idleCycle($sformatf("rnd%0d", i));
        end

        // Cancel in RUN cycle 10: stall drops next cycle, no result, hilo kept.
        prev = hilo_out;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
            end
            if (c == 10) cancel = 1'b1;
            #1;
        end
        checkVal("cancel_stall_same", 64'(stall_div), 64'd1);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        #1;
        checkVal("cancel_stall_next", 64'(stall_div), 64'd0);
        sawValid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (result_valid) sawValid = 1'b1;
        end
        checkVal("cancel_novalid", 64'(sawValid), 64'd0);
        checkVal("cancel_hilo", hilo_out, prev);

        // Cancel together with start in IDLE stays IDLE.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd4;
        #1;
        checkVal("startcancel_stall", 64'(stall_div), 64'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        #1;
        checkVal("startcancel_idle", 64'(stall_div), 64'd0);
        runDiv(32'd9, 32'd4, 1'b0, "after_cancel");
        idleCycle("after_cancel");

        // Back-to-back: second start on the cycle after DONE.
        runDiv(32'd1234567, 32'd89, 1'b0, "b2b_first");
        t1 = lastValidCycle;
        runDiv(-32'sd1000, 32'd7, 1'b1, "b2b_second");
        checkVal("b2b_gap", 64'(lastValidCycle - t1), 64'd34);
        idleCycle("b2b");

        // Reset mid-RUN clears every output on the next cycle.
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1'b1; signed_div = 1'b1; dividend = 32'd77; divisor = 32'd5;
            end
        end
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        #1;
        checkVal("midrst_hilo",  hilo_out, 64'd0);
        checkVal("midrst_stall", 64'(stall_div), 64'd0);
        checkVal("midrst_valid", 64'(result_valid), 64'd0);
        checkVal("midrst_dbz",   64'(div_by_zero), 64'd0);
        rst = 1'b0;
        runDiv(32'd77, 32'd5, 1'b1, "post_rst");
        idleCycle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
